// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU and its program loader.
package cpu19_pkg;

    localparam int unsigned WORD_W         = 19;
    localparam int unsigned BYTES_PER_WORD = 3;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        B0,
        B1,
        B2,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles 19-bit words, writes them into the
// CPU instruction memory and holds the CPU in reset until the load completes.
module prog_loader
    import cpu19_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = cpu19_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    // Number of meaningful bits carried by the last byte of a word.
    localparam int unsigned TOP_BITS = WORD_W - (BYTES_PER_WORD - 1) * 8;

    loader_state_t state, state_nxt;

    logic [15:0] word_cnt;
    logic [15:0] word_len;
    logic [7:0]  byte0_q;
    logic [7:0]  byte1_q;
    logic        xfer;
    logic        ovf;
    logic        last_word;

    assign xfer = in_valid & in_ready;

    always_comb begin
        ovf       = (32'(word_cnt) >> ADDR_W) != 32'd0;
        last_word = (32'(word_cnt) + 32'd1) >= 32'(word_len);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LEN_LO;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LEN_LO: if (xfer) state_nxt = LEN_HI;
            LEN_HI: if (xfer) state_nxt = ({in_data, word_len[7:0]} == 16'd0) ? DONE : B0;
            B0:     if (xfer) state_nxt = B1;
            B1:     if (xfer) state_nxt = B2;
            B2:     if (xfer) state_nxt = WRITE;
            WRITE:  state_nxt = last_word ? DONE : B0;
            DONE:   if (reload) state_nxt = LEN_LO;
            default: state_nxt = LEN_LO;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        imem_we  = 1'b0;
        case (state)
            LEN_LO, LEN_HI, B0, B1, B2: in_ready = 1'b1;
            WRITE:   imem_we = ~ovf;
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
        cpu_rst = busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt   <= '0;
            word_len   <= '0;
            byte0_q    <= '0;
            byte1_q    <= '0;
            imem_wdata <= '0;
            load_err   <= 1'b0;
        end else begin
            case (state)
                LEN_LO: if (xfer) word_len[7:0]  <= in_data;
                LEN_HI: if (xfer) word_len[15:8] <= in_data;
                B0:     if (xfer) byte0_q <= in_data;
                B1:     if (xfer) byte1_q <= in_data;
                B2: begin
                    if (xfer) begin
                        imem_wdata <= {in_data[TOP_BITS-1:0], byte1_q, byte0_q};
                        if (in_data[7:TOP_BITS] != '0) load_err <= 1'b1;
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 16'd1;
                    if (ovf) load_err <= 1'b1;
                end
                DONE: begin
                    if (reload) begin
                        word_cnt <= '0;
                        word_len <= '0;
                        load_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr    = word_cnt[ADDR_W-1:0];
    assign words_loaded = word_cnt;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard per instance.
module tb_prog_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        reload;
    logic [7:0]  in_data;
    logic        in_valid1, in_valid2;

    logic        u1_in_ready, u1_we, u1_cpu_rst, u1_busy, u1_done, u1_err;
    logic [7:0]  u1_addr;
    logic [18:0] u1_wdata;
    logic [15:0] u1_words;

    logic        u2_in_ready, u2_we, u2_cpu_rst, u2_busy, u2_done, u2_err;
    logic [1:0]  u2_addr;
    logic [18:0] u2_wdata;
    logic [15:0] u2_words;

    prog_loader #(.ADDR_W(8), .WORD_W(19)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid1),
        .in_ready(u1_in_ready), .reload(reload), .imem_we(u1_we),
        .imem_addr(u1_addr), .imem_wdata(u1_wdata), .cpu_rst(u1_cpu_rst),
        .busy(u1_busy), .done(u1_done), .load_err(u1_err), .words_loaded(u1_words)
    );

    prog_loader #(.ADDR_W(2), .WORD_W(19)) u2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid2),
        .in_ready(u2_in_ready), .reload(reload), .imem_we(u2_we),
        .imem_addr(u2_addr), .imem_wdata(u2_wdata), .cpu_rst(u2_cpu_rst),
        .busy(u2_busy), .done(u2_done), .load_err(u2_err), .words_loaded(u2_words)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned wr1 = 0, wr2 = 0, push1 = 0, push2 = 0;
    int unsigned cpu_rst_drop = 0;
    bit          watch = 1'b0;
    logic [26:0] q1[$];
    logic [26:0] q2[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        logic [26:0] e;
        if (watch && u1_cpu_rst !== 1'b1) cpu_rst_drop++;
        if (u1_we === 1'b1) begin
            wr1++;
            check("u1_ready_in_write", 32'(u1_in_ready), 32'd0);
            check("u1_write_expected", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("u1_wr_addr", 32'(u1_addr), 32'(e[26:19]));
                check("u1_wr_data", 32'(u1_wdata), 32'(e[18:0]));
            end
        end
        if (u2_we === 1'b1) begin
            wr2++;
            check("u2_write_expected", 32'(q2.size() > 0), 32'd1);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                check("u2_wr_addr", 32'(u2_addr), 32'(e[26:19]));
                check("u2_wr_data", 32'(u2_wdata), 32'(e[18:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit sel, input bit rnd);
        int unsigned guard;
        int unsigned idle;
        if (rnd) begin
            idle = $urandom_range(0, 2);
            repeat (idle) begin @(posedge clk); #1; end
        end
        in_data = b;
        if (sel) in_valid2 = 1'b1; else in_valid1 = 1'b1;
        guard = 0;
        while (((sel ? u2_in_ready : u1_in_ready) !== 1'b1) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("ready_timeout", guard, 32'd0);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic send_word(input logic [18:0] w, input bit sel, input bit rnd);
        send(w[7:0], sel, rnd);
        send(w[15:8], sel, rnd);
        send({5'b0, w[18:16]}, sel, rnd);
    endtask

    task automatic push1_word(input logic [7:0] a, input logic [18:0] w);
        q1.push_back({a, w});
        push1++;
    endtask

    task automatic wait_done(input bit sel);
        int unsigned guard = 0;
        while (((sel ? u2_done : u1_done) !== 1'b1) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("done_reached", 32'(sel ? u2_done : u1_done), 32'd1);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] w;
        rst = 1'b1; reload = 1'b0; in_data = '0; in_valid1 = 1'b0; in_valid2 = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(u1_in_ready), 32'd1);
        check("rst_busy", 32'(u1_busy), 32'd1);
        check("rst_cpu_rst", 32'(u1_cpu_rst), 32'd1);
        check("rst_we", 32'(u1_we), 32'd0);
        check("rst_addr", 32'(u1_addr), 32'd0);
        check("rst_wdata", 32'(u1_wdata), 32'd0);
        check("rst_done", 32'(u1_done), 32'd0);
        check("rst_err", 32'(u1_err), 32'd0);
        check("rst_words", 32'(u1_words), 32'd0);
        rst = 1'b0;

        // N=1, valid held high
        push1_word(8'd0, 19'h5A3C1);
        send(8'h01, 0, 0); send(8'h00, 0, 0);
        send(8'hC1, 0, 0); send(8'hA3, 0, 0); send(8'h05, 0, 0);
        check("t1_we", 32'(u1_we), 32'd1);
        check("t1_addr", 32'(u1_addr), 32'd0);
        check("t1_data", 32'(u1_wdata), 32'h5A3C1);
        check("t1_cpu_rst_during_write", 32'(u1_cpu_rst), 32'd1);
        @(posedge clk); #1;
        check("t1_done", 32'(u1_done), 32'd1);
        check("t1_cpu_rst", 32'(u1_cpu_rst), 32'd0);
        check("t1_words", 32'(u1_words), 32'd1);
        check("t1_err", 32'(u1_err), 32'd0);
        check("t1_writes", wr1, 32'd1);

        // N=3, random valid gaps
        do_reload();
        check("t2_busy", 32'(u1_busy), 32'd1);
        check("t2_done", 32'(u1_done), 32'd0);
        check("t2_cpu_rst", 32'(u1_cpu_rst), 32'd1);
        check("t2_words_clr", 32'(u1_words), 32'd0);
        watch = 1'b1;
        send(8'h03, 0, 1); send(8'h00, 0, 1);
        for (int i = 0; i < 3; i++) begin
            w = 19'($urandom);
            push1_word(8'(i), w);
            send_word(w, 0, 1);
        end
        wait_done(0);
        watch = 1'b0;
        check("t2_words", 32'(u1_words), 32'd3);
        check("t2_err", 32'(u1_err), 32'd0);
        check("t2_writes", wr1, push1);
        check("t2_q_empty", 32'(q1.size()), 32'd0);
        check("t2_cpu_rst_held", cpu_rst_drop, 32'd0);

        // N=0
        do_reload();
        send(8'h00, 0, 0); send(8'h00, 0, 0);
        check("t3_done", 32'(u1_done), 32'd1);
        check("t3_cpu_rst", 32'(u1_cpu_rst), 32'd0);
        check("t3_words", 32'(u1_words), 32'd0);
        check("t3_writes", wr1, push1);

        // byte2 with stray upper bits
        do_reload();
        send(8'h01, 0, 0); send(8'h00, 0, 0);
        push1_word(8'd0, 19'h51234);
        send(8'h34, 0, 0); send(8'h12, 0, 0); send(8'hFD, 0, 0);
        check("t4_err_in_write", 32'(u1_err), 32'd1);
        wait_done(0);
        check("t4_err_done", 32'(u1_err), 32'd1);
        in_data = 8'hAA; in_valid1 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("t4_ready_in_done", 32'(u1_in_ready), 32'd0);
        check("t4_still_done", 32'(u1_done), 32'd1);
        check("t4_err_sticky", 32'(u1_err), 32'd1);
        check("t4_words", 32'(u1_words), 32'd1);
        in_valid1 = 1'b0;
        check("t4_writes", wr1, push1);
        do_reload();
        check("t4_err_clr", 32'(u1_err), 32'd0);

        // rst mid-load of N=4, then complete loads
        watch = 1'b1;
        send(8'h04, 0, 0); send(8'h00, 0, 0);
        push1_word(8'd0, 19'h10203); send_word(19'h10203, 0, 0);
        push1_word(8'd1, 19'h2ABCD); send_word(19'h2ABCD, 0, 0);
        @(posedge clk); #1;
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        check("t6_reload_ignored", 32'(u1_words), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rst_busy", 32'(u1_busy), 32'd1);
        check("t6_rst_ready", 32'(u1_in_ready), 32'd1);
        check("t6_rst_words", 32'(u1_words), 32'd0);
        check("t6_rst_addr", 32'(u1_addr), 32'd0);
        send(8'h04, 0, 1); send(8'h00, 0, 1);
        for (int i = 0; i < 4; i++) begin
            w = 19'($urandom);
            push1_word(8'(i), w);
            send_word(w, 0, 1);
        end
        wait_done(0);
        watch = 1'b0;
        check("t6_words", 32'(u1_words), 32'd4);
        check("t6_cpu_rst_held", cpu_rst_drop, 32'd0);
        do_reload();
        check("t6_reload_addr", 32'(u1_addr), 32'd0);
        send(8'h02, 0, 0); send(8'h00, 0, 0);
        push1_word(8'd0, 19'h7FFFF); send_word(19'h7FFFF, 0, 0);
        push1_word(8'd1, 19'h00001); send_word(19'h00001, 0, 0);
        wait_done(0);
        check("t6_words2", 32'(u1_words), 32'd2);
        check("t6_writes", wr1, push1);
        check("t6_q_empty", 32'(q1.size()), 32'd0);

        // ADDR_W=2, N=5: fifth word overflows
        send(8'h05, 1, 0); send(8'h00, 1, 0);
        for (int i = 0; i < 5; i++) begin
            w = 19'($urandom);
            if (i < 4) begin
                q2.push_back({8'(i), w});
                push2++;
            end
            send_word(w, 1, 0);
        end
        wait_done(1);
        check("t5_writes", wr2, push2);
        check("t5_words", 32'(u2_words), 32'd5);
        check("t5_err", 32'(u2_err), 32'd1);
        check("t5_q_empty", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that sits directly upstream of the 19-bit CPU `top`. It accepts a byte stream over a valid/ready handshake and assembles 19-bit instruction words. It writes those words into the CPU's instruction memory through a single write port. It holds the CPU in reset until the whole program has been written.

## Interface
- `ADDR_W`, 8: instruction memory address width; depth = 2^ADDR_W words.
- `WORD_W`, 19: instruction width; fixed at 19 for this architecture.
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid` and `in_ready` are both high on a rising edge.
- `reload`  in  1  single-cycle request to start a new load; honoured only in DONE.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  19  write data.
- `cpu_rst`  out  1  reset to CPU `top`; high while loading.
- `busy`  out  1  load in progress.
- `done`  out  1  load complete.
- `load_err`  out  1  sticky error flag; cleared by `rst` or an honoured `reload`.
- `words_loaded`  out  16  count of words written this load.

## Operation
- Stream format:
  - 2-byte little-endian word count N.
  - Then N words of 3 bytes each, little-endian.
  - Each word is {byte2[2:0], byte1, byte0}.
- States:
  - LEN_LO, LEN_HI: receive N.
  - B0, B1, B2: receive the three bytes of a word.
  - WRITE: one-cycle write to instruction memory.
  - DONE.
- Transitions:
  - LEN_LO→LEN_HI on a transfer.
  - LEN_HI→B0 on a transfer if N≠0; LEN_HI→DONE if N=0.
  - B0→B1→B2→WRITE, each on a transfer.
  - WRITE→B0 if `words_loaded`+1<N, else WRITE→DONE.
  - DONE→LEN_LO on `reload`.
- `in_ready` is high in LEN_LO, LEN_HI, B0, B1 and B2. It is low in WRITE and DONE. Bytes offered in DONE are neither consumed nor acknowledged.
- Address counter:
  - Starts at 0 for each load and increments after each WRITE.
  - `imem_addr` is the current word index truncated to ADDR_W bits.
- Overflow:
  - Words with index ≥ 2^ADDR_W are consumed but not written (`imem_we` stays low).
  - `load_err` is set.
  - `words_loaded` still counts them.
- If byte2[7:3] is nonzero, `load_err` is set. The word is still written with those bits dropped.
- `busy` is high in every state except DONE.
- `done` is high in DONE.
- `cpu_rst` equals `busy`.

## Timing
- Reset values after the clock edge with `rst` high:
  - State LEN_LO.
  - `in_ready`=1, `busy`=1, `cpu_rst`=1.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `done`=0, `load_err`=0, `words_loaded`=0.
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths, including `in_valid`→`in_ready`.
- Write timing:
  - The third byte of a word is accepted at edge k.
  - `imem_we`=1 with address and data valid during cycle k..k+1 (the WRITE state).
  - The first byte of the next word is accepted at edge k+2 at the earliest.
- Sustained throughput is 1 word per 4 cycles.
- Last write in WRITE cycle w: DONE is entered at edge w+1, so `cpu_rst` falls and `done` rises at w+1.
- N=0: DONE is entered at the edge that accepts LEN_HI.
- `reload` sampled in DONE:
  - LEN_LO is entered at the next edge.
  - `cpu_rst`=1, `done`=0.
  - Counters and `load_err` are cleared.
- `reload` is ignored in all other states.
- `rst` during a load:
  - State returns to LEN_LO and counters are cleared.
  - Memory already written is left as is.
  - `rst` has priority over `reload` and over any transfer.

## Structure
- Shared package `cpu19_pkg` holds:
  - `WORD_W`=19.
  - The loader state typedef with the seven states above.
  - The byte-per-word constant (3).
- The block is a single module with no sub-modules. It is instantiated alongside `top`, with its `cpu_rst` OR-ed with the system reset into `top`'s `rst`.

## Test plan
- N=1, bytes 01 00 C1 A3 05 with `in_valid` held high:
  - Exactly one `imem_we` pulse, addr 0, data 19'h5A3C1.
  - `cpu_rst` falls one cycle after the pulse; `words_loaded`=1; `load_err`=0.
- N=3 with `in_valid` toggling randomly:
  - Writes occur at addresses 0, 1, 2 with the correct words.
  - `in_ready` is low in every WRITE cycle.
  - No byte is lost or duplicated.
- N=0 (bytes 00 00):
  - `done`=1 and `cpu_rst`=0 one edge after the second byte.
  - No `imem_we` pulse.
- Byte2=0xFD:
  - Written data has bits [18:16]=3'b101.
  - `load_err`=1, and it stays set through DONE.
- ADDR_W=2, N=5:
  - Four writes at addresses 0–3; the fifth word is consumed with no write.
  - `load_err`=1; `words_loaded`=5.
- `rst` pulsed after two words of N=4, then a full reload via `reload` after DONE:
  - State restarts at LEN_LO and the address restarts at 0.
  - `cpu_rst` stays high throughout the load.
